// File: rtl/lut_interp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_interp_pkg : shared widths, FSM encoding and saturation helper   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package lut_interp_pkg;

   localparam int NREQ_DEF    = 4;
   localparam int ZH_W_DEF    = 8;
   localparam int ZL_W_DEF    = 4;
   localparam int FUNC_W_DEF  = 12;
   localparam int SLOPE_W_DEF = 7;
   localparam int FUNC_MAX    = (1 << FUNC_W_DEF) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOOK = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic int sat_max(input int w);
      return (1 << w) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lut_interp_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_interp_sched_if : requester, result and ROM signals              |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface lut_interp_sched_if
   import lut_interp_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int ZH_W    = ZH_W_DEF,
   parameter int ZL_W    = ZL_W_DEF,
   parameter int FUNC_W  = FUNC_W_DEF,
   parameter int SLOPE_W = SLOPE_W_DEF
) ();
   logic [NREQ-1:0]             req;
   logic [NREQ*(ZH_W+ZL_W)-1:0] z_in;
   logic [NREQ-1:0]             ack;
   logic [NREQ-1:0]             done;
   logic [FUNC_W-1:0]           y_out;
   logic                        busy;
   logic [ZH_W-1:0]             rom_zh;
   logic [FUNC_W-1:0]           func_in;
   logic [SLOPE_W-1:0]          slope_in;

   // Master is the client/ROM side, slave is the scheduler.
   modport master (
      output req, z_in, func_in, slope_in,
      input  ack, done, y_out, busy, rom_zh
   );
   modport slave (
      input  req, z_in, func_in, slope_in,
      output ack, done, y_out, busy, rom_zh
   );
endinterface
`default_nettype wire

// File: rtl/lut_interp_sched_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb : combinational round-robin picker, first request at/after ptr |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arb #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [PTR_W-1:0] win_o,
   output logic             valid_o
);
   int   w_idx;
   logic w_found;

   always_comb begin
      grant_o = '0;
      win_o   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(ptr_i) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && req_i[w_idx]) begin
            w_found        = 1'b1;
            grant_o[w_idx] = 1'b1;
            win_o          = PTR_W'(w_idx);
         end
      end
      valid_o = w_found;
   end
endmodule
`default_nettype wire

// File: rtl/lut_interp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_interp_sched : shared ROM pair, y = func[zH] + (slope*zL >> ZL_W) |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module lut_interp_sched
   import lut_interp_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int ZH_W    = ZH_W_DEF,
   parameter int ZL_W    = ZL_W_DEF,
   parameter int FUNC_W  = FUNC_W_DEF,
   parameter int SLOPE_W = SLOPE_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   lut_interp_sched_if.slave bus
);
   localparam int c_ZW    = ZH_W + ZL_W;
   localparam int c_ACC_W = SLOPE_W + ZL_W;
   localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_CNT_W = (ZL_W > 1) ? $clog2(ZL_W) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ZL_W - 1);
   localparam logic [FUNC_W:0]    c_SAT      = (FUNC_W+1)'(sat_max(FUNC_W));
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NREQ - 1);

   state_t               state_q, state_d;
   logic [c_PTR_W-1:0]   ptr_q, ptr_d;
   logic [c_PTR_W-1:0]   id_q, id_d;
   logic [ZL_W-1:0]      zl_q, zl_d;
   logic [ZH_W-1:0]      rom_zh_q, rom_zh_d;
   logic [FUNC_W-1:0]    func_q, func_d;
   logic [c_ACC_W-1:0]   mcand_q, mcand_d;
   logic [c_ACC_W-1:0]   acc_q, acc_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic [FUNC_W-1:0]    y_q, y_d;
   logic [NREQ-1:0]      done_q, done_d;

   logic [NREQ-1:0]      w_grant;
   logic [c_PTR_W-1:0]   w_win;
   logic                 w_any;
   logic [NREQ-1:0]      w_ack;
   logic [c_ZW-1:0]      w_zsel;
   logic [c_ACC_W-1:0]   w_acc_nxt;
   logic [FUNC_W:0]      w_sum;

   rr_arb #(.NREQ(NREQ), .PTR_W(c_PTR_W)) u_arb (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .grant_o (w_grant),
      .win_o   (w_win),
      .valid_o (w_any)
   );

   assign w_zsel = bus.z_in[w_win*c_ZW +: c_ZW];

   // Multiplicand is pre-shifted each cycle so the current zL bit is always bit 0.
   assign w_acc_nxt = acc_q + (zl_q[0] ? mcand_q : '0);
   assign w_sum     = {1'b0, func_q} + (FUNC_W+1)'(w_acc_nxt >> ZL_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         zl_q     <= '0;
         rom_zh_q <= '0;
         func_q   <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         zl_q     <= zl_d;
         rom_zh_q <= rom_zh_d;
         func_q   <= func_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      zl_d     = zl_q;
      rom_zh_d = rom_zh_q;
      func_d   = func_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      done_d   = '0;
      w_ack    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (w_any) begin
               w_ack    = w_grant;
               zl_d     = w_zsel[ZL_W-1:0];
               rom_zh_d = w_zsel[c_ZW-1:ZL_W];
               id_d     = w_win;
               ptr_d    = (w_win == c_PTR_LAST) ? '0 : w_win + 1'b1;
               state_d  = ST_LOOK;
            end
         end
         ST_LOOK: begin
            func_d  = bus.func_in;
            mcand_d = c_ACC_W'(bus.slope_in);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_MUL;
         end
         ST_MUL: begin
            acc_d   = w_acc_nxt;
            mcand_d = mcand_q << 1;
            zl_d    = zl_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            // Result is registered on the final step so done lands in the DONE cycle.
            if (cnt_q == c_CNT_LAST) begin
               y_d     = (w_sum > c_SAT) ? c_SAT[FUNC_W-1:0] : w_sum[FUNC_W-1:0];
               done_d  = NREQ'(1) << id_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.ack    = w_ack;
   assign bus.done   = done_q;
   assign bus.y_out  = y_q;
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.rom_zh = rom_zh_q;
endmodule
`default_nettype wire

// File: tb/tb_lut_interp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lut_interp_sched : directed checks of lut_interp_sched            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_lut_interp_sched;
   import lut_interp_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   lut_interp_sched_if bus ();

   lut_interp_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic int rom_f(input int zh);
      case (zh)
         255:     return 1924;
         254:     return 1805;
         253:     return 4095;
         default: return zh * 4;
      endcase
   endfunction

   function automatic int rom_s(input int zh);
      case (zh)
         255:     return 119;
         254:     return 114;
         253:     return 127;
         default: return zh & 127;
      endcase
   endfunction

   function automatic int exp_y(input int zh, input int zl);
      int s;
      s = rom_f(zh) + ((rom_s(zh) * zl) / 16);
      return (s > FUNC_MAX) ? FUNC_MAX : s;
   endfunction

   // Combinational ROM pair driven from the registered index.
   always_comb begin
      bus.func_in  = 12'(rom_f(int'(bus.rom_zh)));
      bus.slope_in = 7'(rom_s(int'(bus.rom_zh)));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic set_z(input int i, input int zh, input int zl);
      bus.z_in[i*12 +: 12] = {8'(zh), 4'(zl)};
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge after done.
   task automatic single(input string tag, input int i, input int zh, input int zl);
      set_z(i, zh, zl);
      bus.req = 4'(1 << i);
      #1;
      chk({tag, "_ack"}, 32'(bus.ack), 32'(1 << i));
      chk({tag, "_busy_c0"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.req = '0;
      chk({tag, "_romzh"}, 32'(bus.rom_zh), 32'(zh));
      chk({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
      repeat (4) @(negedge clk);
      chk({tag, "_done_c5"}, 32'(bus.done), 32'd0);
      @(negedge clk);
      chk({tag, "_done_c6"}, 32'(bus.done), 32'(1 << i));
      chk({tag, "_y"}, 32'(bus.y_out), 32'(exp_y(zh, zl)));
      @(negedge clk);
      chk({tag, "_done_c7"}, 32'(bus.done), 32'd0);
      chk({tag, "_y_hold"}, 32'(bus.y_out), 32'(exp_y(zh, zl)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_g;
      int t;
      int id;
      last_g   = 0;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.z_in = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_y", 32'(bus.y_out), 32'd0);
      chk("rst_romzh", 32'(bus.rom_zh), 32'd0);

      single("r0_zl0", 0, 255, 0);     // y = 1924
      single("r2_zl8", 2, 254, 8);     // y = 1805 + 57 = 1862
      single("r3_sat", 3, 253, 15);    // y saturates to 4095

      // Requester 1 wins (pointer wraps to 0 after r3); abort it mid-multiply.
      set_z(1, 20, 9);
      bus.req = 4'b0010;
      #1;
      chk("abort_ack", 32'(bus.ack), 32'b0010);
      @(negedge clk);
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_romzh", 32'(bus.rom_zh), 32'd0);
      chk("abort_y", 32'(bus.y_out), 32'd0);

      // All four hold req from reset release: grants must start at 0 and rotate.
      for (int i = 0; i < 4; i++) set_z(i, 10 + i, 3 + 4 * i);
      @(negedge clk);
      bus.req = 4'b1111;
      rst_n   = 1'b1;
      #1;
      for (int g = 0; g < 5; g++) begin
         id = g % 4;
         t  = 0;
         while (bus.ack == 0 && t < 10) begin
            @(negedge clk);
            t++;
         end
         chk("rr_ack", 32'(bus.ack), 32'(1 << id));
         if (g > 0) chk("rr_period", 32'(cyc_n - last_g), 32'd7);
         last_g = cyc_n;
         repeat (6) @(negedge clk);
         chk("rr_done", 32'(bus.done), 32'(1 << id));
         chk("rr_y", 32'(bus.y_out), 32'(exp_y(10 + id, 3 + 4 * id)));
         @(negedge clk);
      end
      bus.req = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
